// File: rtl/actuator_pulse_pkg.sv
// Shared types for the actuator pulse driver: FSM state encoding and duration width.
package actuator_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ON    = 2'd1,
    GUARD = 2'd2
  } state_e;

  localparam int DUR_W = 8;
endpackage

// File: rtl/actuator_pulse_if.sv
// Request/progress bundle between the pet FSM (master) and the actuator driver (slave).
interface actuator_pulse_if;
  import actuator_pkg::*;

  logic             req;
  logic [DUR_W-1:0] duration;
  logic             cancel;
  logic             actuator_out;
  logic             busy;
  logic             done;

  modport master (output req, duration, cancel, input actuator_out, busy, done);
  modport slave  (input req, duration, cancel, output actuator_out, busy, done);
endinterface

// File: rtl/actuator_pulse_tick_gen.sv
// Free-running prescaler: tick_o is high on the last cycle of each TICK_CYCLES window.
module tick_gen #(
    parameter int TICK_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic tick_o
);
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_CYCLES - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + PW'(1);
        if (clear_i || cnt_q == LAST) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick_o = (cnt_q == LAST);
endmodule

// File: rtl/actuator_pulse.sv
// Timed actuator driver: holds the line active for a requested number of ticks,
// then enforces a guard interval before the next request is accepted.
module actuator_pulse
    import actuator_pkg::*;
#(
    parameter int TICK_CYCLES   = 10,
    parameter int MIN_OFF_TICKS = 4,
    parameter bit IDLE_LEVEL    = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    actuator_pulse_if.slave  bus
);
    localparam int GW = $clog2(MIN_OFF_TICKS + 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(MIN_OFF_TICKS - 1);

    state_e           state_q, state_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [DUR_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [GW-1:0]    guard_q, guard_d;
    logic             act_q, act_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             clear;
    logic             tick;

    tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .clear_i (clear),
        .tick_o  (tick)
    );

    always_comb begin
        state_d    = state_q;
        dur_d      = dur_q;
        tick_cnt_d = tick_cnt_q;
        guard_d    = guard_q;
        done_d     = 1'b0;
        clear      = 1'b0;
        case (state_q)
            IDLE: begin
                // Holding the prescaler clear here aligns tick phase to ON entry.
                clear      = 1'b1;
                tick_cnt_d = '0;
                guard_d    = '0;
                if (bus.req && !bus.cancel) begin
                    if (bus.duration != '0) begin
                        dur_d   = bus.duration;
                        state_d = ON;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ON: begin
                if (bus.cancel || (tick && (tick_cnt_q + DUR_W'(1)) == dur_q)) begin
                    state_d    = GUARD;
                    done_d     = 1'b1;
                    clear      = 1'b1;
                    tick_cnt_d = '0;
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + DUR_W'(1);
                end
            end
            GUARD: begin
                if (tick) begin
                    if (guard_q == GUARD_LAST) begin
                        state_d = IDLE;
                        guard_d = '0;
                        clear   = 1'b1;
                    end else begin
                        guard_d = guard_q + GW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        act_d  = (state_d == ON) ? ~IDLE_LEVEL : IDLE_LEVEL;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            dur_q      <= '0;
            tick_cnt_q <= '0;
            guard_q    <= '0;
            act_q      <= IDLE_LEVEL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dur_q      <= dur_d;
            tick_cnt_q <= tick_cnt_d;
            guard_q    <= guard_d;
            act_q      <= act_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.actuator_out = act_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_actuator_pulse.sv
// Scoreboard bench: a timeline model predicts every output cycle; a monitor compares.
module tb_actuator_pulse;
    import actuator_pkg::*;

    localparam int T  = 10;
    localparam int MO = 4;
    localparam bit IL = 1'b1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    actuator_pulse_if ifc ();

    actuator_pulse #(.TICK_CYCLES(T), .MIN_OFF_TICKS(MO), .IDLE_LEVEL(IL)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic act;
        logic busy;
        logic done;
        int   slot;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Timeline model: output slot n is the interval after clock edge n.
    // ON covers slots [on_start, on_end), GUARD covers [on_end, guard_end).
    int on_start  = -1;
    int on_end    = -1;
    int guard_end = 0;
    int done_at   = -1;
    int e         = 0;

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                on_start  = -1;
                on_end    = -1;
                guard_end = 0;
                done_at   = -1;
                exp_q.delete();
            end else begin
                e = e + 1;
                if (e - 1 >= guard_end) begin
                    if (ifc.req && !ifc.cancel) begin
                        if (ifc.duration != 0) begin
                            on_start  = e;
                            on_end    = e + int'(ifc.duration) * T;
                            guard_end = on_end + MO * T;
                        end else begin
                            done_at = e;
                        end
                    end
                end else if (e - 1 >= on_start && e - 1 < on_end && ifc.cancel) begin
                    on_end    = e;
                    guard_end = e + MO * T;
                end
                x.act  = (e >= on_start && e < on_end) ? ~IL : IL;
                x.busy = (e >= on_start && e < guard_end);
                x.done = (e == on_end) || (e == done_at);
                x.slot = e;
                exp_q.push_back(x);
            end
        end
    end

    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checks = checks + 1;
                if (ifc.actuator_out !== x.act || ifc.busy !== x.busy || ifc.done !== x.done) begin
                    errors = errors + 1;
                    $display("FAIL slot %0d: got act/busy/done=%b%b%b expected %b%b%b",
                             x.slot, ifc.actuator_out, ifc.busy, ifc.done, x.act, x.busy, x.done);
                end
            end
        end
    end

    task automatic check_idle(input string name);
        checks = checks + 1;
        if (ifc.actuator_out !== IL || ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL %s: got act/busy/done=%b%b%b expected %b00",
                     name, ifc.actuator_out, ifc.busy, ifc.done, IL);
        end
    endtask

    task automatic step(input logic r, input logic [DUR_W-1:0] d, input logic c);
        ifc.req      = r;
        ifc.duration = d;
        ifc.cancel   = c;
        @(negedge clk);
        ifc.req    = 1'b0;
        ifc.cancel = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, DUR_W'($urandom), 1'b0);
    endtask

    initial begin
        int n;
        ifc.req      = 1'b0;
        ifc.duration = '0;
        ifc.cancel   = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset_state");
        rst_n = 1'b1;
        idle(2);

        // basic pulse
        step(1'b1, 8'd3, 1'b0);
        idle(75);

        // cancel 15 cycles into a long pulse
        step(1'b1, 8'd200, 1'b0);
        idle(14);
        step(1'b0, 8'd0, 1'b1);
        idle(45);

        // request inside GUARD is dropped; request on first idle cycle is taken
        step(1'b1, 8'd2, 1'b0);
        idle(25);
        step(1'b1, 8'd5, 1'b0);
        n = 0;
        while (ifc.busy && n < 200) begin
            step(1'b0, 8'd0, 1'b0);
            n = n + 1;
        end
        if (n >= 200) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL busy_timeout: busy still %b after %0d cycles, expected 0", ifc.busy, n);
        end
        step(1'b1, 8'd1, 1'b0);
        idle(60);

        // zero duration
        step(1'b1, 8'd0, 1'b0);
        idle(3);

        // asynchronous reset on the 12th ON cycle
        step(1'b1, 8'd5, 1'b0);
        idle(11);
        #2 rst_n = 1'b0;
        #1 check_idle("async_reset");
        @(negedge clk);
        check_idle("held_reset");
        rst_n = 1'b1;
        step(1'b1, 8'd1, 1'b0);
        idle(55);

        // req+cancel together in IDLE, then maximum duration
        step(1'b1, 8'd9, 1'b1);
        idle(3);
        step(1'b1, 8'd255, 1'b0);
        idle(2550 + MO * T + 5);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(7) == 0),
                 ($urandom_range(3) == 0) ? DUR_W'(0) : DUR_W'($urandom_range(1, 12)),
                 ($urandom_range(24) == 0));
        end
        idle(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
